// File: rtl/vr_pkg.sv
// Shared VeriRISC definitions: bus widths, instruction-cycle phases and opcodes.
package vr_pkg;

  localparam int OPC_W   = 3;
  localparam int PHASE_W = 3;

  typedef enum logic [PHASE_W-1:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  typedef enum logic [OPC_W-1:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_e;

  // Opcodes that read an operand from memory and write the accumulator.
  function automatic logic is_aluop(input opcode_e op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/counter.sv
// Loadable up-counter with synchronous active-high reset and count enable.
module counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enab,
  input  logic [WIDTH-1:0] cnt_in,
  output logic [WIDTH-1:0] cnt_out
);

  // Load takes priority over counting; the count wraps naturally at the top.
  always_ff @(posedge clk) begin
    if (rst)
      cnt_out <= '0;
    else if (load)
      cnt_out <= cnt_in;
    else if (enab)
      cnt_out <= cnt_out + 1'b1;
  end

endmodule

// File: rtl/seq_controller.sv
// VeriRISC instruction sequencer: walks the 8-phase cycle and decodes the
// datapath strobes from phase, opcode and the accumulator-zero flag.
module seq_controller
  import vr_pkg::*;
#(
  parameter int OPC_W   = vr_pkg::OPC_W,
  parameter int PHASE_W = vr_pkg::PHASE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               zero,
  output logic [PHASE_W-1:0] phase,
  output logic               sel,
  output logic               rd,
  output logic               ld_ir,
  output logic               inc_pc,
  output logic               ld_pc,
  output logic               ld_ac,
  output logic               wr,
  output logic               data_e,
  output logic               halt
);

  logic    halted;
  logic    hlt_at_op_addr;
  logic    enab;
  phase_e  ph;
  opcode_e op;

  assign ph             = phase_e'(phase);
  assign op             = opcode_e'(opcode);
  assign hlt_at_op_addr = (ph == OP_ADDR) && (op == HLT);
  // Freezing the counter on the HLT edge keeps it parked at OP_ADDR.
  assign enab           = ~halted & ~hlt_at_op_addr;

  counter #(
    .WIDTH (PHASE_W)
  ) u_phase_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (1'b0),
    .enab    (enab),
    .cnt_in  ('0),
    .cnt_out (phase)
  );

  always_ff @(posedge clk) begin
    if (rst)
      halted <= 1'b0;
    else if (hlt_at_op_addr)
      halted <= 1'b1;
  end

  // Once halted every strobe drops, so the PC stays on the HLT address.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    if (halted) begin
      halt = 1'b1;
    end else begin
      case (ph)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = (op != HLT);
          halt   = (op == HLT);
        end
        OP_FETCH: begin
          rd = is_aluop(op);
        end
        ALU_OP: begin
          rd     = is_aluop(op);
          inc_pc = (op == SKZ) && zero;
          ld_pc  = (op == JMP);
          data_e = (op == STO);
        end
        STORE: begin
          rd     = is_aluop(op);
          ld_ac  = is_aluop(op);
          ld_pc  = (op == JMP);
          data_e = (op == STO);
          wr     = (op == STO);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_controller.sv
// Scoreboard bench for seq_controller: directed instruction cycles with
// hand-computed strobe tables, checked by an independent monitor.
module tb_seq_controller;

  logic       clk;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic [2:0] phase;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [2:0] phase;
    logic [8:0] strobes;
  } exp_t;

  exp_t sbQ[$];

  // Strobe order: {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}
  logic [8:0] addTbl [8] = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
                             9'b000100000, 9'b010000000, 9'b010000000, 9'b010001000};
  logic [8:0] stoTbl [8] = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
                             9'b000100000, 9'b000000000, 9'b000000010, 9'b000000110};
  logic [8:0] skz1Tbl [8] = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
                              9'b000100000, 9'b000000000, 9'b000100000, 9'b000000000};
  logic [8:0] skz0Tbl [8] = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
                              9'b000100000, 9'b000000000, 9'b000000000, 9'b000000000};
  logic [8:0] jmpTbl [8] = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
                             9'b000100000, 9'b000000000, 9'b000010000, 9'b000010000};
  logic [8:0] hltTbl [8] = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
                             9'b000000001, 9'b000000001, 9'b000000001, 9'b000000001};
  localparam logic [8:0] HALTED = 9'b000000001;

  seq_controller dut (
    .clk    (clk),
    .rst    (rst),
    .opcode (opcode),
    .zero   (zero),
    .phase  (phase),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .ld_ac  (ld_ac),
    .wr     (wr),
    .data_e (data_e),
    .halt   (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits for an edge, drives the next inputs, and records what the DUT
  // must present for the rest of this cycle.
  task automatic applyStimulus(input logic r, input logic [2:0] op, input logic z,
                               input logic [2:0] expPhase, input logic [8:0] expStrobes,
                               input string name);
    exp_t e;
    @(posedge clk);
    #1;
    rst    = r;
    opcode = op;
    zero   = z;
    e.name    = name;
    e.phase   = expPhase;
    e.strobes = expStrobes;
    sbQ.push_back(e);
  endtask

  task automatic runPhases(input logic [2:0] op, input logic z, input logic [8:0] tbl [8],
                           input int first, input int last, input string name);
    for (int p = first; p <= last; p++)
      applyStimulus(1'b0, op, z, 3'(p), tbl[p], $sformatf("%s_p%0d", name, p));
  endtask

  task automatic checkOutput(input exp_t e);
    logic [8:0] got;
    got = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};
    checks++;
    if (phase !== e.phase) begin
      errors++;
      $display("[TB] FAIL %s phase: got %0d expected %0d", e.name, phase, e.phase);
    end
    checks++;
    if (got !== e.strobes) begin
      errors++;
      $display("[TB] FAIL %s strobes: got %b expected %b", e.name, got, e.strobes);
    end
    checks++;
    if ((wr && rd) || (ld_pc && inc_pc)) begin
      errors++;
      $display("[TB] FAIL %s exclusion: wr=%b rd=%b ld_pc=%b inc_pc=%b expected no overlap",
               e.name, wr, rd, ld_pc, inc_pc);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbQ.size() > 0) begin
        e = sbQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin : stimulus
    int budget;
    rst    = 1'b1;
    opcode = 3'd2;
    zero   = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] reset release, ADD cycle");
    runPhases(3'd2, 1'b0, addTbl, 0, 7, "add");
    $display("[TB] STO cycle");
    runPhases(3'd6, 1'b0, stoTbl, 0, 7, "sto");
    $display("[TB] SKZ with zero set and clear");
    runPhases(3'd1, 1'b1, skz1Tbl, 0, 7, "skz1");
    runPhases(3'd1, 1'b0, skz0Tbl, 0, 7, "skz0");
    $display("[TB] JMP cycle");
    runPhases(3'd7, 1'b0, jmpTbl, 0, 7, "jmp");

    $display("[TB] HLT and hold");
    runPhases(3'd0, 1'b0, hltTbl, 0, 4, "hlt");
    for (int i = 0; i < 12; i++)
      applyStimulus(1'b0, 3'd0, 1'b0, 3'd4, HALTED, $sformatf("halted%0d", i));
    applyStimulus(1'b1, 3'd0, 1'b0, 3'd4, HALTED, "halted_rst");
    applyStimulus(1'b0, 3'd7, 1'b0, 3'd0, jmpTbl[0], "post_halt_p0");

    $display("[TB] reset mid-JMP");
    runPhases(3'd7, 1'b0, jmpTbl, 1, 5, "jmpa");
    applyStimulus(1'b1, 3'd7, 1'b0, 3'd6, jmpTbl[6], "jmpa_p6_rst");
    applyStimulus(1'b0, 3'd7, 1'b0, 3'd0, jmpTbl[0], "jmpb_p0");
    runPhases(3'd7, 1'b0, jmpTbl, 1, 7, "jmpb");
    applyStimulus(1'b0, 3'd2, 1'b0, 3'd0, addTbl[0], "wrap_p0");

    budget = 20;
    while (sbQ.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (sbQ.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d entries left expected 0", sbQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
